// File: rtl/fp_pkg.sv
// Shared types for the 13-bit fp_t format: {sign, exp[3:0], man[7:0]},
// value = (-1)^sign * 0.man * 2^exp.
package fp_pkg;

  localparam int EXP_W = 4;
  localparam int MAN_W = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = 4'hF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  localparam fp_t FP_ZERO = '0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ALIGN    = 3'd1,
    ST_ADD      = 3'd2,
    ST_NORM     = 3'd3,
    ST_DONE_CHK = 3'd4,
    ST_OUT      = 3'd5
  } state_t;

  // A zero mantissa means zero whatever the exponent field holds.
  function automatic logic is_zero(input fp_t v);
    return (v.man == '0);
  endfunction

endpackage

// File: rtl/fp_normalize_step.sv
// One combinational normalize step on a 9-bit sum mantissa: carry right-shift,
// overflow saturation value, zero forcing, or a single left-shift.
module fp_normalize_step
  import fp_pkg::*;
(
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [MAN_W:0]   i_man,
  output logic             o_sign,
  output logic [EXP_W-1:0] o_exp,
  output logic [MAN_W:0]   o_man,
  output logic             o_done,
  output logic             o_ovf
);

  always_comb begin
    o_sign = i_sign;
    o_exp  = i_exp;
    o_man  = i_man;
    o_done = 1'b1;
    o_ovf  = 1'b0;
    if (i_man[MAN_W]) begin
      if (i_exp == EXP_MAX) begin
        o_ovf = 1'b1;
        o_exp = EXP_MAX;
        o_man = {1'b0, {MAN_W{1'b1}}};
      end else begin
        o_man = i_man >> 1;
        o_exp = i_exp + 1'b1;
      end
    end else if (i_man == '0) begin
      o_sign = 1'b0;
      o_exp  = '0;
    end else if (!i_man[MAN_W-1] && (i_exp != '0)) begin
      // Another cycle is needed to see whether the shifted value is normalized.
      o_man  = i_man << 1;
      o_exp  = i_exp - 1'b1;
      o_done = 1'b0;
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// Multi-cycle fp_t stream accumulator: align, sign-magnitude add, normalize,
// and present the total after the operand flagged last.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter logic SAT_ON_OVF = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] out_data,
  output logic        overflow
);

  state_t           r_state;
  state_t           w_state_nx;
  fp_t              r_acc;
  fp_t              r_op;
  fp_t              r_out;
  logic             r_last;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_ovf;
  logic [MAN_W:0]   r_sum;
  logic             r_sign;
  logic [EXP_W-1:0] r_exp;

  fp_t              w_in;
  logic             w_in_fire;
  logic             w_exp_eq;
  logic             w_acc_small;
  logic [EXP_W-1:0] w_diff;
  logic             w_far;
  logic             w_same_sign;
  logic             w_acc_ge;
  logic             w_n_sign;
  logic [EXP_W-1:0] w_n_exp;
  logic [MAN_W:0]   w_n_man;
  logic             w_n_done;
  logic             w_n_ovf;

  assign w_in        = fp_t'(in_data);
  assign w_in_fire   = in_valid && r_in_ready;
  assign w_exp_eq    = (r_acc.exp == r_op.exp);
  assign w_acc_small = (r_acc.exp < r_op.exp);
  assign w_diff      = w_acc_small ? (r_op.exp - r_acc.exp) : (r_acc.exp - r_op.exp);
  assign w_far       = (w_diff > 4'd8);
  assign w_same_sign = (r_acc.sign == r_op.sign);
  assign w_acc_ge    = (r_acc.man >= r_op.man);

  fp_normalize_step u_norm (
    .i_sign (r_sign),
    .i_exp  (r_exp),
    .i_man  (r_sum),
    .o_sign (w_n_sign),
    .o_exp  (w_n_exp),
    .o_man  (w_n_man),
    .o_done (w_n_done),
    .o_ovf  (w_n_ovf)
  );

  // ---- control: state register and next-state logic ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_in_ready <= (w_state_nx == ST_IDLE);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:     if (w_in_fire) w_state_nx = is_zero(r_acc) ? ST_DONE_CHK : ST_ALIGN;
      ST_ALIGN:    if (w_exp_eq) w_state_nx = ST_ADD;
      ST_ADD:      w_state_nx = ST_NORM;
      ST_NORM:     if (w_n_done) w_state_nx = ST_DONE_CHK;
      ST_DONE_CHK: w_state_nx = r_last ? ST_OUT : ST_IDLE;
      ST_OUT:      if (out_ready) w_state_nx = ST_IDLE;
      default:     w_state_nx = ST_IDLE;
    endcase
  end

  // ---- accumulator, result register and sticky overflow ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= FP_ZERO;
      r_out       <= FP_ZERO;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_fire) begin
            r_last <= in_last;
            if (is_zero(r_acc)) r_acc <= w_in;
          end
        end
        ST_ALIGN: begin
          if (!w_exp_eq && w_acc_small) begin
            if (w_far) begin
              r_acc <= '{sign: r_acc.sign, exp: r_op.exp, man: '0};
            end else begin
              r_acc.man <= r_acc.man >> 1;
              r_acc.exp <= r_acc.exp + 1'b1;
            end
          end
        end
        ST_NORM: begin
          if (w_n_done) begin
            if (w_n_ovf) begin
              r_ovf <= 1'b1;
              if (SAT_ON_OVF) r_acc <= '{sign: w_n_sign, exp: w_n_exp, man: w_n_man[MAN_W-1:0]};
            end else begin
              r_acc <= '{sign: w_n_sign, exp: w_n_exp, man: w_n_man[MAN_W-1:0]};
            end
          end
        end
        ST_DONE_CHK: begin
          if (r_last) begin
            r_out       <= r_acc;
            r_out_valid <= 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_acc       <= FP_ZERO;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- operand, add and normalize working registers ----
  always_ff @(posedge clk) begin
    case (r_state)
      ST_IDLE: begin
        if (w_in_fire) r_op <= w_in;
      end
      ST_ALIGN: begin
        if (!w_exp_eq && !w_acc_small) begin
          if (w_far) begin
            r_op <= '{sign: r_op.sign, exp: r_acc.exp, man: '0};
          end else begin
            r_op.man <= r_op.man >> 1;
            r_op.exp <= r_op.exp + 1'b1;
          end
        end
      end
      ST_ADD: begin
        r_exp <= r_acc.exp;
        if (w_same_sign) begin
          r_sum  <= {1'b0, r_acc.man} + {1'b0, r_op.man};
          r_sign <= r_acc.sign;
        end else if (w_acc_ge) begin
          r_sum  <= {1'b0, r_acc.man} - {1'b0, r_op.man};
          r_sign <= r_acc.sign;
        end else begin
          r_sum  <= {1'b0, r_op.man} - {1'b0, r_acc.man};
          r_sign <= r_op.sign;
        end
      end
      ST_NORM: begin
        if (!w_n_done) begin
          r_sign <= w_n_sign;
          r_exp  <= w_n_exp;
          r_sum  <= w_n_man;
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed and random sums against an arithmetic reference model, with a
// scoreboard of expected totals and sticky-overflow flags.
module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [12:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        overflow;
  logic [12:0] out_data;

  int          tests = 0;
  int          fails = 0;
  logic [13:0] sbq[$];
  logic [12:0] m_acc = '0;
  logic        m_ovf = 1'b0;

  localparam int LIMIT = 100;

  always #5 clk = ~clk;

  fp_accumulator #(.SAT_ON_OVF(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow)
  );

  // Returns {overflow, sum} of acc + op with truncating alignment.
  function automatic logic [13:0] model_add(input logic [12:0] a, input logic [12:0] b);
    int   ea, eb, ma, mb, e, sum;
    logic sg;
    ea = int'(a[11:8]); eb = int'(b[11:8]);
    ma = int'(a[7:0]);  mb = int'(b[7:0]);
    if (ma == 0) return {1'b0, b};
    e  = (ea > eb) ? ea : eb;
    ma = ((e - ea) > 8) ? 0 : (ma >> (e - ea));
    mb = ((e - eb) > 8) ? 0 : (mb >> (e - eb));
    if (a[12] == b[12]) begin sum = ma + mb; sg = a[12]; end
    else if (ma >= mb)  begin sum = ma - mb; sg = a[12]; end
    else                begin sum = mb - ma; sg = b[12]; end
    if (sum > 255) begin
      if (e == 15) return {1'b1, sg, 4'hF, 8'hFF};
      sum = sum >> 1;
      e   = e + 1;
    end else if (sum == 0) begin
      return 14'h0;
    end else begin
      while (sum < 128 && e > 0) begin sum = sum << 1; e = e - 1; end
    end
    return {1'b0, sg, e[3:0], sum[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tmo(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed no handshake, expected one within %0d cycles", tag, LIMIT);
  endtask

  task automatic send(input logic [12:0] d, input logic l);
    int          n;
    logic [13:0] r;
    n = 0;
    while (!in_ready && n < LIMIT) begin @(posedge clk); #1; n++; end
    if (!in_ready) tmo("in_ready wait");
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    r     = model_add(m_acc, d);
    m_acc = r[12:0];
    m_ovf = m_ovf | r[13];
    if (l) begin
      sbq.push_back({m_ovf, m_acc});
      m_acc = '0;
      m_ovf = 1'b0;
    end
  endtask

  task automatic collect(input string tag, input logic use_plan, input logic [12:0] plan,
                         output int lat);
    logic [13:0] e;
    lat = 0;
    out_ready = 1'b1;
    while (!out_valid && lat < LIMIT) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin
      tmo(tag);
      out_ready = 1'b0;
    end else if (sbq.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed output %h, expected none queued", tag, out_data);
      @(posedge clk); #1;
      out_ready = 1'b0;
    end else begin
      e = sbq.pop_front();
      chk($sformatf("%s data", tag), out_data, e[12:0]);
      chk($sformatf("%s ovf", tag), {12'b0, overflow}, {12'b0, e[13]});
      if (use_plan) chk($sformatf("%s plan", tag), out_data, plan);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk($sformatf("%s vld drop", tag), {12'b0, out_valid}, 13'h0);
      chk($sformatf("%s ovf clear", tag), {12'b0, overflow}, 13'h0);
    end
  endtask

  initial begin
    int          lat;
    int          n;
    int          len;
    logic [7:0]  man;
    logic [12:0] op;

    // reset state
    #1;
    chk("rst in_ready", {12'b0, in_ready}, 13'h0);
    chk("rst out_valid", {12'b0, out_valid}, 13'h0);
    chk("rst out_data", out_data, 13'h0);
    chk("rst overflow", {12'b0, overflow}, 13'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle in_ready", {12'b0, in_ready}, 13'h1);

    // directed sums
    send(13'h0180, 1'b0); send(13'h0180, 1'b1);
    collect("carry", 1'b1, 13'h0280, lat);
    chk("carry latency", 13'(lat), 13'd4);

    send(13'h03A0, 1'b0); send(13'h0290, 1'b1);
    collect("align1", 1'b1, 13'h03E8, lat);
    chk("align1 latency", 13'(lat), 13'd5);

    send(13'h0080, 1'b0); send(13'h11F0, 1'b1);
    collect("negsum", 1'b1, 13'h11B0, lat);

    send(13'h02C0, 1'b0); send(13'h12C0, 1'b1);
    collect("cancel", 1'b1, 13'h0000, lat);

    send(13'h0180, 1'b0); send(13'h1170, 1'b1);
    collect("underflow", 1'b1, 13'h0020, lat);

    send(13'h0A80, 1'b0); send(13'h01FF, 1'b1);
    collect("far", 1'b1, 13'h0A80, lat);

    // random sums against the model
    for (int s = 0; s < 16; s++) begin
      len = int'($urandom_range(1, 4));
      for (int k = 0; k < len; k++) begin
        man = 8'($urandom_range(1, 255));
        if ($urandom_range(0, 3) != 0) man[7] = 1'b1;
        op = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), man};
        send(op, (k == len - 1));
      end
      collect("rand", 1'b0, 13'h0, lat);
    end

    // saturating overflow with a stalled consumer
    send(13'h0F80, 1'b0); send(13'h0F80, 1'b1);
    n = 0;
    while (!out_valid && n < LIMIT) begin @(posedge clk); #1; n++; end
    if (!out_valid) tmo("ovf wait");
    for (int i = 0; i < 5; i++) begin
      chk("stall data", out_data, 13'h0FFF);
      chk("stall in_ready", {12'b0, in_ready}, 13'h0);
      chk("stall ovf", {12'b0, overflow}, 13'h1);
      @(posedge clk); #1;
    end
    collect("sat", 1'b1, 13'h0FFF, lat);

    // reset during ALIGN aborts the sum
    send(13'h0180, 1'b0); send(13'h0980, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", {12'b0, in_ready}, 13'h0);
    chk("abort out_valid", {12'b0, out_valid}, 13'h0);
    chk("abort out_data", out_data, 13'h0);
    chk("abort overflow", {12'b0, overflow}, 13'h0);
    sbq.delete();
    m_acc = '0;
    m_ovf = 1'b0;
    @(posedge clk); #1;
    chk("abort hold in_ready", {12'b0, in_ready}, 13'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst in_ready", {12'b0, in_ready}, 13'h1);
    send(13'h02A0, 1'b1);
    collect("fresh", 1'b1, 13'h02A0, lat);
    chk("fresh latency", 13'(lat), 13'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Sequential accumulator for the team's 13-bit `fp_t` format, sitting directly downstream of the input operand source and upstream of result capture. It consumes a stream of `fp_t` operands over a valid/ready handshake and sums them into an internal accumulator with a multi-cycle align/add/normalize datapath. When the operand flagged `in_last` has been added, it presents the total on an output handshake.

## Interface
- `SAT_ON_OVF`, default 1: 1 = saturate on exponent overflow; 0 = hold the pre-overflow accumulator value.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand present on `in_data`.
- `in_ready`  out  1  block can accept an operand; high only in IDLE.
- `in_data`  in  13 (`fp_t`)  operand.
- `in_last`  in  1  operand is the final one of the sum; sampled with `in_data`.
- `out_valid`  out  1  `out_data` holds a completed sum.
- `out_ready`  in  1  consumer accepts the sum.
- `out_data`  out  13 (`fp_t`)  accumulated result, registered.
- `overflow`  out  1  sticky; set when exponent overflow occurred in the current sum; cleared when the sum is delivered.

## Operation
- Format `fp_t` = {sign[12], exp[11:8], man[7:0]}. Value is (-1)^sign × 0.man × 2^exp, with `exp` unsigned 0..15. A value is normalized when man[7]=1. Zero is man=0, exp=0, sign=0.
- Handshake transfer occurs when valid and ready are both high on a clock edge.
- FSM states:
  - IDLE: `in_ready`=1. On transfer, latch the operand and `in_last`, then go to ALIGN. If the accumulator is zero, load the operand directly and go to DONE_CHK.
  - ALIGN: the operand with the smaller exponent shifts its mantissa right 1 bit and increments its exponent, one step per cycle, until the exponents are equal. If the exponent difference is greater than 8, the smaller operand is zeroed in one cycle. When the exponents are equal, go to ADD.
  - ADD: sign-magnitude add into a 9-bit result.
    - Same signs: add the magnitudes.
    - Different signs: subtract the smaller magnitude from the larger; the result takes the sign of the larger.
    - Go to NORM.
  - NORM:
    - Carry out (bit 8 set): shift right 1 and exp+1. This takes one cycle.
    - Carry with exp=15: overflow; set `overflow`. Result is {sign, F, FF} if `SAT_ON_OVF`=1; otherwise the accumulator is unchanged.
    - Otherwise, while man[7]=0, man≠0 and exp>0: shift left 1 and exp−1, one step per cycle.
    - man=0: force +0.
    - exp reaching 0 with man[7]=0: leave unnormalized.
    - Go to DONE_CHK.
  - DONE_CHK: if the latched last flag is 0, go to IDLE. If it is 1, copy the accumulator to `out_data`, assert `out_valid`, and go to OUT.
  - OUT: hold `out_valid` and `out_data` until `out_ready`. On transfer, clear the accumulator to +0, clear `overflow`, and go to IDLE.
- Rounding is truncation; bits shifted out are discarded.

## Timing
- Reset values: `in_ready`=0 during reset, then 1 in IDLE; `out_valid`=0; `out_data`=0; `overflow`=0; accumulator=+0; state=IDLE.
- Per-operand latency from the accepting edge: 1 (ALIGN entry) + d (d = exponent difference, 1 if d>8) + 1 (ADD) + n (NORM steps, minimum 1) + 1 (DONE_CHK).
  - Worst case is 1+8+1+8+1 = 19 cycles.
  - Zero-accumulator load takes 2 cycles.
- `in_ready` is low from the accepting edge until DONE_CHK returns to IDLE, so operands are never dropped.
- `out_data` is stable while `out_valid`=1. `out_valid` deasserts on the cycle after the transfer edge.
- Asserting `rst_n` low mid-operation aborts immediately: the partial sum is lost and all outputs take their reset values asynchronously.
- `in_valid` with `in_last` in the same cycle as an output stall is impossible, because `in_ready`=0 in OUT.

## Structure
- Shared package `fp_pkg`: `fp_t` packed struct, `EXP_W`=4, `MAN_W`=8, `EXP_MAX`=4'hF, `FP_ZERO` constant, and the FSM state enum.
- One sub-module, `fp_normalize_step`: combinational, one normalize step (right-shift on carry / left-shift / zero detect / overflow flag). The FSM calls it each NORM cycle.

## Test plan
- {0,1,80} then {0,1,80} with last → `out_data`={0,2,80}; `overflow`=0.
- {0,3,A0} then {0,2,90} last → ALIGN takes 1 cycle; `out_data`={0,3,E8}.
- {0,0,80} then {1,1,F0} last → `out_data`={1,1,B0}.
- {0,2,C0} then {1,2,C0} last → `out_data`={0,0,00}.
- {0,F,80} then {0,F,80} last, with `SAT_ON_OVF`=1 → `out_data`={0,F,FF}; `overflow`=1 until delivery.
- Hold `out_ready`=0 for 5 cycles → `out_data` stable and `in_ready`=0. Separately, pulse `rst_n` low during ALIGN → all outputs go to reset values, and the next sum starts from +0.
